// File: rtl/fsm_step_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : fsm_step_sequencer_if
//  Description : Bundles the control, table-write and step-output signals of
//                the step sequencer into one interface.
//                master : the block driving the sequencer (state manager/host)
//                slave  : the sequencer itself
//  Signals     : sCurrent  current state fed back from the state manager
//                XRaw      raw branch-select input, not debounced
//                RUN       auto-step enable
//                STEP      single-step request
//                TW_EN     transition-table write enable
//                TW_ADDR   table entry (state) to write
//                TW_SEL    0: write branch0, 1: write branch1
//                TW_DATA   value to write
//                sNext0    next-state candidate for X=0
//                sNext1    next-state candidate for X=1
//                NXT       one-cycle step strobe
//                X         branch select, stable while NXT=1
//                BUSY      high whenever the sequencer is not idle
//  Revision    : 1.0 - initial release
// ============================================================================
interface fsm_step_sequencer_if #(
    parameter int STATE_W = 3
);
    logic [STATE_W-1:0] sCurrent;
    logic               XRaw;
    logic               RUN;
    logic               STEP;
    logic               TW_EN;
    logic [STATE_W-1:0] TW_ADDR;
    logic               TW_SEL;
    logic [STATE_W-1:0] TW_DATA;
    logic [STATE_W-1:0] sNext0;
    logic [STATE_W-1:0] sNext1;
    logic               NXT;
    logic               X;
    logic               BUSY;

    modport master (
        output sCurrent, XRaw, RUN, STEP, TW_EN, TW_ADDR, TW_SEL, TW_DATA,
        input  sNext0, sNext1, NXT, X, BUSY
    );

    modport slave (
        input  sCurrent, XRaw, RUN, STEP, TW_EN, TW_ADDR, TW_SEL, TW_DATA,
        output sNext0, sNext1, NXT, X, BUSY
    );
endinterface
`default_nettype wire

// File: rtl/fsm_step_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fsm_step_sequencer
//  Description : Upstream driver of the state-manager stage. Looks up both
//                next-state candidates for the fed-back sCurrent in a writable
//                transition table, debounces the raw branch input into X and
//                issues one-cycle NXT strobes on demand (STEP) or periodically
//                (RUN).
//  Ports       : CLK   clock, rising edge
//                RST   synchronous active-high reset
//                bus   fsm_step_sequencer_if.slave (see interface header)
//  Parameters  : STATE_W     state width, table has 2**STATE_W x 2 entries
//                TICK_DIV    IDLE cycles between auto steps while RUN=1 (>=1)
//                DEB_LEN     cycles XRaw must differ before X source flips (>=1)
//                START_STATE reset value of sNext0/sNext1
//  Revision    : 1.0 - initial release
// ============================================================================
module fsm_step_sequencer #(
    parameter int                 STATE_W     = 3,
    parameter int                 TICK_DIV    = 4,
    parameter int                 DEB_LEN     = 3,
    parameter logic [STATE_W-1:0] START_STATE = STATE_W'(1)
) (
    input  wire logic            CLK,
    input  wire logic            RST,
    fsm_step_sequencer_if.slave  bus
);

    localparam int c_DEPTH  = 2 ** STATE_W;
    localparam int c_TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_DEB_W  = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_DIV - 1);
    localparam logic [c_DEB_W-1:0]  c_DEB_LAST  = c_DEB_W'(DEB_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_ISSUE   = 3'd2,
        S_SETTLE1 = 3'd3,
        S_SETTLE2 = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_stateNext;
    logic [c_TICK_W-1:0]  r_tick;
    logic                 w_tickExpire;
    logic [c_DEB_W-1:0]   r_debCnt;
    logic                 r_deb;
    logic [STATE_W-1:0]   r_tblB0 [c_DEPTH];
    logic [STATE_W-1:0]   r_tblB1 [c_DEPTH];
    logic [STATE_W-1:0]   r_sNext0;
    logic [STATE_W-1:0]   r_sNext1;
    logic                 r_nxt;
    logic                 r_x;

    // Default branch1 successor: rotate left by one (001->010->100->001).
    function automatic logic [STATE_W-1:0] f_rotl(input logic [STATE_W-1:0] v);
        return {v[STATE_W-2:0], v[STATE_W-1]};
    endfunction

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    assign w_tickExpire = bus.RUN && (r_tick == c_TICK_LAST);

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_IDLE:    if (bus.STEP || w_tickExpire) w_stateNext = S_LOAD;
            S_LOAD:    w_stateNext = S_ISSUE;
            S_ISSUE:   w_stateNext = S_SETTLE1;
            S_SETTLE1: w_stateNext = S_SETTLE2;
            S_SETTLE2: w_stateNext = S_IDLE;
            default:   w_stateNext = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Tick counter: only runs while sitting in IDLE with RUN held; any exit
    // from IDLE (STEP or expiry) or a dropped RUN restarts the period.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_tick <= '0;
        end else if ((r_state == S_IDLE) && bus.RUN && (w_stateNext == S_IDLE)) begin
            r_tick <= r_tick + 1'b1;
        end else begin
            r_tick <= '0;
        end
    end

    // ------------------------------------------------------------------------
    // Debounce: count consecutive cycles of disagreement; the flip happens on
    // the edge where the count would reach DEB_LEN.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_debCnt <= '0;
            r_deb    <= 1'b0;
        end else if (bus.XRaw == r_deb) begin
            r_debCnt <= '0;
        end else if (r_debCnt == c_DEB_LAST) begin
            r_debCnt <= '0;
            r_deb    <= ~r_deb;
        end else begin
            r_debCnt <= r_debCnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Transition table. A LOAD on the same edge as a write reads the old
    // entry because both sides are sampled at the edge.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_tblB0[i] <= STATE_W'(i);
                r_tblB1[i] <= f_rotl(STATE_W'(i));
            end
        end else if (bus.TW_EN) begin
            if (bus.TW_SEL) begin
                r_tblB1[bus.TW_ADDR] <= bus.TW_DATA;
            end else begin
                r_tblB0[bus.TW_ADDR] <= bus.TW_DATA;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output registers. X is only updated in LOAD so it cannot move while the
    // strobe is high.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sNext0 <= START_STATE;
            r_sNext1 <= START_STATE;
            r_x      <= 1'b0;
            r_nxt    <= 1'b0;
        end else begin
            if (r_state == S_LOAD) begin
                r_sNext0 <= r_tblB0[bus.sCurrent];
                r_sNext1 <= r_tblB1[bus.sCurrent];
                r_x      <= r_deb;
            end
            r_nxt <= (r_state == S_ISSUE);
        end
    end

    assign bus.sNext0 = r_sNext0;
    assign bus.sNext1 = r_sNext1;
    assign bus.X      = r_x;
    assign bus.NXT    = r_nxt;
    assign bus.BUSY   = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fsm_step_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fsm_step_sequencer
//  Description : Self-checking bench for fsm_step_sequencer. Directed
//                scenarios followed by random stimulus, compared every cycle
//                against a behavioural model (step countdown, table arrays,
//                run-length debounce).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fsm_step_sequencer;

    localparam int c_TICK_DIV = 4;
    localparam int c_DEB_LEN  = 3;

    logic CLK;
    logic RST;
    int   nChecks;
    int   nErrors;

    fsm_step_sequencer_if #(.STATE_W(3)) bus ();

    fsm_step_sequencer #(
        .STATE_W     (3),
        .TICK_DIV    (c_TICK_DIV),
        .DEB_LEN     (c_DEB_LEN),
        .START_STATE (3'b001)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    logic [2:0] m_tb0 [8];
    logic [2:0] m_tb1 [8];
    int         m_busyLeft;   // cycles of activity left after an accepted step
    int         m_idleRun;    // consecutive IDLE cycles with RUN held
    int         m_diffRun;    // consecutive cycles XRaw disagreed with m_deb
    logic       m_deb;
    bit         m_live = 1'b0;
    logic [2:0] e_s0, e_s1;
    logic       e_x, e_nxt, e_busy;

    always @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 8; i++) begin
                m_tb0[i] = 3'(i);
                m_tb1[i] = 3'((i * 2) % 8 + i / 4);
            end
            m_busyLeft = 0;
            m_idleRun  = 0;
            m_diffRun  = 0;
            m_deb      = 1'b0;
            e_s0 = 3'b001; e_s1 = 3'b001; e_x = 1'b0; e_nxt = 1'b0; e_busy = 1'b0;
            m_live = 1'b1;
        end else if (m_live) begin
            if (m_busyLeft == 4) begin
                e_s0 = m_tb0[bus.sCurrent];
                e_s1 = m_tb1[bus.sCurrent];
                e_x  = m_deb;
            end
            e_nxt = (m_busyLeft == 3);
            if (bus.TW_EN) begin
                if (bus.TW_SEL) m_tb1[bus.TW_ADDR] = bus.TW_DATA;
                else            m_tb0[bus.TW_ADDR] = bus.TW_DATA;
            end
            if (bus.XRaw != m_deb) m_diffRun++;
            else                   m_diffRun = 0;
            if (m_diffRun == c_DEB_LEN) begin
                m_deb     = ~m_deb;
                m_diffRun = 0;
            end
            if (m_busyLeft > 0) begin
                m_busyLeft--;
                m_idleRun = 0;
            end else if (bus.STEP || (bus.RUN && m_idleRun == c_TICK_DIV - 1)) begin
                m_busyLeft = 4;
                m_idleRun  = 0;
            end else begin
                m_idleRun = bus.RUN ? m_idleRun + 1 : 0;
            end
            e_busy = (m_busyLeft != 0);
        end
    end

    always @(negedge CLK) begin
        if (m_live) begin
            check("nxt",    32'(bus.NXT),    32'(e_nxt));
            check("busy",   32'(bus.BUSY),   32'(e_busy));
            check("sNext0", 32'(bus.sNext0), 32'(e_s0));
            check("sNext1", 32'(bus.sNext1), 32'(e_s1));
            check("x",      32'(bus.X),      32'(e_x));
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #2;
        end
    endtask

    task automatic doStep(input logic [2:0] cur);
        bus.sCurrent = cur;
        bus.STEP = 1'b1;
        cyc();
        bus.STEP = 1'b0;
        cyc(4);
    endtask

    initial begin
        nChecks = 0;
        nErrors = 0;
        RST = 1'b1;
        bus.sCurrent = 3'b001; bus.XRaw = 1'b0; bus.RUN = 1'b0; bus.STEP = 1'b0;
        bus.TW_EN = 1'b0; bus.TW_ADDR = '0; bus.TW_SEL = 1'b0; bus.TW_DATA = '0;
        cyc(2);
        RST = 1'b0;

        // Reset state, independent constants
        check("rst_nxt",  32'(bus.NXT),    32'd0);
        check("rst_x",    32'(bus.X),      32'd0);
        check("rst_busy", 32'(bus.BUSY),   32'd0);
        check("rst_sn0",  32'(bus.sNext0), 32'd1);
        check("rst_sn1",  32'(bus.sNext1), 32'd1);

        // Table readback of the defaults over every entry
        for (int s = 0; s < 8; s++) doStep(3'(s));

        // Single step from 001, with a dropped re-pulse during BUSY
        bus.sCurrent = 3'b001;
        bus.STEP = 1'b1;
        cyc();                       // after edge 0: LOAD
        bus.STEP = 1'b0;
        check("t2_busy0", 32'(bus.BUSY), 32'd1);
        cyc(2);                      // after edge 2
        check("t2_nxt",   32'(bus.NXT),    32'd1);
        check("t2_sn0",   32'(bus.sNext0), 32'd1);
        check("t2_sn1",   32'(bus.sNext1), 32'd2);
        bus.STEP = 1'b1;             // sampled while still busy
        cyc();
        bus.STEP = 1'b0;
        check("t2_nxt3",  32'(bus.NXT), 32'd0);
        cyc(6);
        check("t2_idle",  32'(bus.BUSY), 32'd0);

        // Debounce: 2-cycle glitch ignored, 3-cycle level taken
        bus.XRaw = 1'b1; cyc(2); bus.XRaw = 1'b0; cyc(2);
        doStep(3'b001);
        check("t3_glitch", 32'(bus.X), 32'd0);
        bus.XRaw = 1'b1; cyc(4);
        doStep(3'b001);
        check("t3_level",  32'(bus.X), 32'd1);
        bus.XRaw = 1'b0; cyc(4);

        // Auto stepping from 010, then RUN dropped mid-count
        bus.sCurrent = 3'b010;
        bus.RUN = 1'b1;
        cyc(34);
        check("t4_sn1", 32'(bus.sNext1), 32'd4);
        bus.RUN = 1'b0;
        cyc(20);

        // Table write, then a write colliding with LOAD of the same entry
        bus.TW_EN = 1'b1; bus.TW_ADDR = 3'b001; bus.TW_SEL = 1'b1; bus.TW_DATA = 3'b100;
        cyc();
        bus.TW_EN = 1'b0;
        doStep(3'b001);
        check("t5_write", 32'(bus.sNext1), 32'd4);
        bus.sCurrent = 3'b001;
        bus.STEP = 1'b1;
        cyc();
        bus.STEP = 1'b0;
        bus.TW_EN = 1'b1; bus.TW_DATA = 3'b111;
        cyc();
        bus.TW_EN = 1'b0;
        cyc(3);
        check("t5_old", 32'(bus.sNext1), 32'd4);
        doStep(3'b001);
        check("t5_new", 32'(bus.sNext1), 32'd7);

        // Reset during the strobe restores defaults
        bus.STEP = 1'b1;
        cyc();
        bus.STEP = 1'b0;
        cyc(2);
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        check("t6_nxt",  32'(bus.NXT),  32'd0);
        check("t6_busy", 32'(bus.BUSY), 32'd0);
        doStep(3'b001);
        check("t6_sn1",  32'(bus.sNext1), 32'd2);

        // Random phase
        for (int i = 0; i < 1500; i++) begin
            RST          = ($urandom_range(0, 249) == 0);
            bus.STEP     = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 29) == 0) bus.RUN = ~bus.RUN;
            if ($urandom_range(0, 3) == 0) bus.XRaw = ~bus.XRaw;
            bus.sCurrent = 3'($urandom_range(0, 7));
            bus.TW_EN    = ($urandom_range(0, 7) == 0);
            bus.TW_ADDR  = 3'($urandom_range(0, 7));
            bus.TW_SEL   = 1'($urandom_range(0, 1));
            bus.TW_DATA  = 3'($urandom_range(0, 7));
            cyc();
        end
        RST = 1'b0; bus.STEP = 1'b0; bus.RUN = 1'b0; bus.TW_EN = 1'b0;
        cyc(4);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
`default_nettype wire
